// File: rtl/de_regfile_scoreboard.sv
// Decode-stage GPR/CSR register file with per-register pending-write counters.
// Produces source operands (with WB write-through), the DE stall and the issue strobe.
module de_regfile_scoreboard #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int REGWORDS  = 32,
  parameter int CSRNOBITS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_wr_reg_i,
  input  logic [REGNOBITS-1:0] wb_wregno_i,
  input  logic [DBITS-1:0]     wb_regval_i,
  input  logic                 wb_wr_csr_i,
  input  logic [CSRNOBITS-1:0] wb_wcsrno_i,
  input  logic                 de_valid_i,
  input  logic                 flush_i,
  input  logic [REGNOBITS-1:0] rs1_i,
  input  logic [REGNOBITS-1:0] rs2_i,
  input  logic                 rs1_used_i,
  input  logic                 rs2_used_i,
  input  logic [REGNOBITS-1:0] rd_i,
  input  logic                 rd_wr_i,
  input  logic [CSRNOBITS-1:0] csr_rdno_i,
  output logic [DBITS-1:0]     rs1_val_o,
  output logic [DBITS-1:0]     rs2_val_o,
  output logic [DBITS-1:0]     csr_val_o,
  output logic                 hazard_o,
  output logic                 issue_o
);

  localparam logic [CSRNOBITS-1:0] CSR_MTVEC    = CSRNOBITS'(12'h305);
  localparam logic [CSRNOBITS-1:0] CSR_MSCRATCH = CSRNOBITS'(12'h340);
  localparam logic [CSRNOBITS-1:0] CSR_MEPC     = CSRNOBITS'(12'h341);
  localparam logic [CSRNOBITS-1:0] CSR_MCAUSE   = CSRNOBITS'(12'h342);

  logic [DBITS-1:0]    gpr_q [REGWORDS];
  logic [1:0]          pend_q [REGWORDS];
  logic [1:0]          pend_d [REGWORDS];
  logic [DBITS-1:0]    mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic                gpr_we, csr_we, inc_en;
  logic [1:0]          pend_rs1, pend_rs2, pend_rd;
  logic                rs1_hz, rs2_hz, struct_hz, de_live;
  logic [REGWORDS-1:0] inc_vec, dec_vec;

  function automatic logic in_range(input logic [REGNOBITS-1:0] r);
    return 32'(r) < REGWORDS;
  endfunction

  function automatic logic is_csr(input logic [CSRNOBITS-1:0] c);
    return (c == CSR_MTVEC) || (c == CSR_MSCRATCH) || (c == CSR_MEPC) || (c == CSR_MCAUSE);
  endfunction

  // A matching WB write retires one pending write in the same cycle, so it only
  // unblocks a source that has exactly one outstanding write.
  function automatic logic src_hz(input logic used, input logic [1:0] p, input logic wb_hit);
    return used & ((p > 2'd1) | ((p == 2'd1) & ~wb_hit));
  endfunction

  // Writes are discarded while reset is high; gpr_we doubles as the dec strobe.
  assign gpr_we = wb_wr_reg_i & (wb_wregno_i != '0) & in_range(wb_wregno_i) & ~reset;
  assign csr_we = wb_wr_csr_i & ~reset;

  assign pend_rs1 = in_range(rs1_i) ? pend_q[rs1_i] : 2'd0;
  assign pend_rs2 = in_range(rs2_i) ? pend_q[rs2_i] : 2'd0;
  assign pend_rd  = in_range(rd_i)  ? pend_q[rd_i]  : 2'd0;

  assign rs1_hz    = src_hz(rs1_used_i, pend_rs1, gpr_we && (wb_wregno_i == rs1_i));
  assign rs2_hz    = src_hz(rs2_used_i, pend_rs2, gpr_we && (wb_wregno_i == rs2_i));
  assign struct_hz = rd_wr_i & (rd_i != '0) & (pend_rd == 2'd3) &
                     ~(gpr_we & (wb_wregno_i == rd_i));

  assign de_live  = ~reset & de_valid_i & ~flush_i;
  assign hazard_o = de_live & (rs1_hz | rs2_hz | struct_hz);
  assign issue_o  = de_live & ~hazard_o;
  assign inc_en   = issue_o & rd_wr_i & (rd_i != '0) & in_range(rd_i);

  always_comb begin
    rs1_val_o = '0;
    rs2_val_o = '0;
    if (!reset && rs1_i != '0 && in_range(rs1_i))
      rs1_val_o = (gpr_we && wb_wregno_i == rs1_i) ? wb_regval_i : gpr_q[rs1_i];
    if (!reset && rs2_i != '0 && in_range(rs2_i))
      rs2_val_o = (gpr_we && wb_wregno_i == rs2_i) ? wb_regval_i : gpr_q[rs2_i];
  end

  always_comb begin
    csr_val_o = '0;
    case (csr_rdno_i)
      CSR_MTVEC:    csr_val_o = mtvec_q;
      CSR_MSCRATCH: csr_val_o = mscratch_q;
      CSR_MEPC:     csr_val_o = mepc_q;
      CSR_MCAUSE:   csr_val_o = mcause_q;
      default:      csr_val_o = '0;
    endcase
    if (csr_we && wb_wcsrno_i == csr_rdno_i && is_csr(csr_rdno_i)) csr_val_o = wb_regval_i;
    if (reset) csr_val_o = '0;
  end

  // inc and dec on the same register cancel; dec of an idle counter saturates at 0.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < REGWORDS; r++) begin
      inc_vec[r] = inc_en && (rd_i == REGNOBITS'(r));
      dec_vec[r] = gpr_we && (wb_wregno_i == REGNOBITS'(r));
      pend_d[r]  = pend_q[r];
      if (r == 0) begin
        pend_d[r] = 2'd0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (pend_q[r] != 2'd3) pend_d[r] = pend_q[r] + 2'd1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (pend_q[r] != 2'd0) pend_d[r] = pend_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) begin
        gpr_q[r]  <= '0;
        pend_q[r] <= 2'd0;
      end
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      for (int r = 0; r < REGWORDS; r++) pend_q[r] <= pend_d[r];
      if (gpr_we) gpr_q[wb_wregno_i] <= wb_regval_i;
      if (csr_we) begin
        case (wb_wcsrno_i)
          CSR_MTVEC:    mtvec_q    <= wb_regval_i;
          CSR_MSCRATCH: mscratch_q <= wb_regval_i;
          CSR_MEPC:     mepc_q     <= wb_regval_i;
          CSR_MCAUSE:   mcause_q   <= wb_regval_i;
          default:      ;
        endcase
      end
    end
  end

endmodule
